div_unit: RTL and testbench

//  Iterative radix-2 restoring divider; producer side of the HI/LO register write interface.

---
 rtl/div_if.sv | 24 ++
 rtl/div_unit.sv | 120 ++++++++++++
 tb/tb_div_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// rtl/div_if.sv - EX-stage request and HI/LO result bundle for the iterative divider
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic             cancel;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             stall_o;
    logic             result_valid;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start, signed_div, cancel, dividend, divisor,
        input  stall_o, result_valid, hi_o, lo_o
    );

    modport slave (
        input  start, signed_div, cancel, dividend, divisor,
        output stall_o, result_valid, hi_o, lo_o
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring DIV/DIVU unit feeding the HI/LO registers
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             launch;
    logic             last_step;

    // operand sign/magnitude extraction; signs only matter for DIV
    always_comb begin
        a_neg = bus.signed_div & bus.dividend[WIDTH-1];
        b_neg = bus.signed_div & bus.divisor[WIDTH-1];
        a_mag = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
        b_mag = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    end

    // one restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial = {rem, quo[WIDTH-1]};
        diff  = trial - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

    assign launch    = (state == S_IDLE) & bus.start & ~bus.cancel;
    assign last_step = (cnt == CW'(WIDTH - 1));

    // control FSM, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        rem   <= '0;
                        quo   <= a_mag;
                        dvs   <= b_mag;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= '0;
                        if (bus.divisor == '0) begin
                            // divide-by-zero: fixed result, raw dividend, no sign fixup
                            lo_q  <= '1;
                            hi_q  <= bus.dividend;
                            state <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.cancel) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (last_step) begin
                            lo_q  <= neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
                            hi_q  <= neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall_o      = (state == S_BUSY) | launch;
    assign bus.result_valid = (state == S_DONE) & ~bus.cancel;
    assign bus.hi_o         = hi_q;
    assign bus.lo_o         = lo_q;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // issue one op in the current cycle (cycle 0) and follow it to completion
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int exp_lat);
        int lat;
        logic stall_ok;
        bus.signed_div = sgn;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.start      = 1'b1;
        @(negedge clk);
        check({tag, "_stall_c0"}, 32'(bus.stall_o), 32'd1);
        next_cycle();
        bus.start = 1'b0;
        lat = 1;
        stall_ok = 1'b1;
        @(negedge clk);
        while (!bus.result_valid && lat < 40) begin
            if (!bus.stall_o) stall_ok = 1'b0;
            next_cycle();
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
        check({tag, "_stall_done"}, 32'(bus.stall_o), 32'd0);
        check({tag, "_lo"}, bus.lo_o, exp_lo);
        check({tag, "_hi"}, bus.hi_o, exp_hi);
        next_cycle();
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.cancel     = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        rst            = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_hi", bus.hi_o, 32'd0);
        check("rst_lo", bus.lo_o, 32'd0);
        rst = 1'b1;
        next_cycle();

        // T1..T4
        run_div("t1_divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div("t2_div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        run_div("t2_div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33);
        run_div("t3_div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33);
        run_div("t3_divu_min_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);
        run_div("t4_divu_by_zero", 1'b0, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1);
        run_div("t4_div_neg_by_zero", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1);
        run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33);

        // T5: cancel in cycle 10 of an op started in cycle 0
        begin
            logic seen_valid;
            seen_valid = 1'b0;
            bus.signed_div = 1'b0;
            bus.dividend   = 32'd500;
            bus.divisor    = 32'd3;
            bus.start      = 1'b1;
            next_cycle();
            bus.start = 1'b0;
            for (int c = 1; c < 10; c++) begin
                @(negedge clk);
                if (bus.result_valid) seen_valid = 1'b1;
                next_cycle();
            end
            bus.cancel = 1'b1;
            @(negedge clk);
            if (bus.result_valid) seen_valid = 1'b1;
            next_cycle();
            bus.cancel = 1'b0;
            check("t5_stall_c11", 32'(bus.stall_o), 32'd0);
            check("t5_no_valid", 32'(seen_valid | bus.result_valid), 32'd0);
            check("t5_lo_kept", bus.lo_o, 32'hFFFFFFFF);
            check("t5_hi_kept", bus.hi_o, 32'd0);
        end
        run_div("t5_restart", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 33);

        // T5: cancel during DONE masks result_valid
        bus.signed_div = 1'b0;
        bus.dividend   = 32'd9;
        bus.divisor    = 32'd0;
        bus.start      = 1'b1;
        next_cycle();
        bus.start  = 1'b0;
        bus.cancel = 1'b1;
        @(negedge clk);
        check("t5_done_cancel_valid", 32'(bus.result_valid), 32'd0);
        next_cycle();
        bus.cancel = 1'b0;
        @(negedge clk);
        check("t5_done_cancel_idle_stall", 32'(bus.stall_o), 32'd0);
        next_cycle();

        // T6: asynchronous reset mid-cycle 20 of an op started in cycle 0
        bus.signed_div = 1'b0;
        bus.dividend   = 32'd1000;
        bus.divisor    = 32'd7;
        bus.start      = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        repeat (19) next_cycle();
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_stall", 32'(bus.stall_o), 32'd0);
        check("t6_async_valid", 32'(bus.result_valid), 32'd0);
        check("t6_async_hi", bus.hi_o, 32'd0);
        check("t6_async_lo", bus.lo_o, 32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        run_div("t6_after_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
